sdram_line_prefetch: RTL and testbench
======================================

SDRAM_LINE_PREFETCH -- requirements
Module: sdram_line_prefetch

Interface
REQ-001 Parameter: BASE_ADDR, default 25'h0, SDRAM word address of pixel (0,0).
REQ-002 Parameter: H_PIXELS, default 640, words (pixels) per line, one 16-bit SDRAM word per pixel.
REQ-003 Parameter: V_LINES, default 480, lines per frame.
REQ-004 Port: Clk  in  1  single system clock; all logic on its rising edge.
REQ-005 Port: Reset  in  1  synchronous, active-low reset.
REQ-006 Port: fetch_req  in  1  one-cycle pulse; start prefetch of line fetch_line.
REQ-007 Port: fetch_line  in  10  line to prefetch; sampled only when fetch_req=1.
REQ-008 Port: disp_line  in  10  line currently displayed; bit 0 selects the read bank.
REQ-009 Port: pix_x  in  10  pixel column to read.
REQ-010 Port: pix_valid  in  1  display-enable qualifier for pix_x.
REQ-011 Port: pixel_out  out  12  RGB444 pixel {R,G,B}, registered.
REQ-012 Port: sdram_Addr  out  25  word address presented to the SDRAM controller.
REQ-013 Port: sdram_Focus  out  1  read request; held high for the whole line fetch.
REQ-014 Port: sdram_Dout  in  16  read data from the controller.
REQ-015 Port: sdram_R  in  1  one-cycle strobe; sdram_Dout valid for current sdram_Addr.
REQ-016 Port: busy  out  1  high while state=FETCH.
REQ-017 Port: underrun  out  1  sticky; set when a fetch is aborted before completion.

Function
REQ-018 Storage: two banks of H_PIXELS x 12 bits; line L fills bank L[0], display reads bank disp_line[0].
REQ-019 FSM states IDLE and FETCH only.
REQ-020 IDLE -> FETCH on fetch_req=1 with fetch_line < V_LINES; latch line, word count := 0.
REQ-021 fetch_req with fetch_line >= V_LINES is ignored, no state change, no flag.
REQ-022 In FETCH: sdram_Focus=1, sdram_Addr = BASE_ADDR + line*H_PIXELS + count, computed in 25 bits.
REQ-023 sdram_Addr shall be registered and stable between sdram_R strobes.
REQ-024 On sdram_R=1 in FETCH: write sdram_Dout[11:0] to bank line[0] at index count; count += 1; sdram_Addr advances next cycle.
REQ-025 sdram_R with count = H_PIXELS-1 completes the line: FETCH -> IDLE, sdram_Focus=0 on the next cycle.
REQ-026 sdram_R while IDLE is ignored: no buffer write.
REQ-027 fetch_req in FETCH, valid line: abort current fetch, set underrun, restart from count 0 for new line; sdram_Focus stays high.
REQ-028 If fetch_req and a final sdram_R coincide, the final word is written, underrun is not set, and the new fetch starts.
REQ-029 Read path: pixel_out(t+1) = bank[disp_line[0]][pix_x] if pix_valid(t)=1 and pix_x < H_PIXELS, else 12'h000.
REQ-030 Same-bank read/write collisions: read returns old data; no stall.
REQ-031 sdram_Dout[15:12] are discarded.

Reset
REQ-032 Reset=0 at a rising edge: state IDLE, count 0, sdram_Focus 0, sdram_Addr 0, pixel_out 0, busy 0, underrun 0.
REQ-033 Reset mid-fetch drops sdram_Focus on the same edge; no further buffer writes occur.
REQ-034 Line buffer contents are not reset.
REQ-035 underrun is cleared only by Reset.

Verification
REQ-036 fetch_req, line 0, BASE_ADDR 0, controller returns Dout = addr on every 3rd cycle -> addresses 0..639 issued in order, Focus falls after word 639, bank 0 holds 0..639 (low 12 bits).
REQ-037 fetch line 479 -> first sdram_Addr 306560, last 307199; busy falls exactly one cycle after the final strobe.
REQ-038 Line 1 filled, disp_line=1, pix_valid=1, pix_x=5 -> pixel_out equals word 5 of line 1 one cycle later; pix_valid=0 -> 12'h000.
REQ-039 fetch_req line 2 at count 100, then fetch_req line 3 -> underrun=1, sdram_Addr jumps to 1920, line 3 completes correctly.
REQ-040 fetch_req line 480 in IDLE -> no Focus, busy 0; Reset=0 during a fetch at count 50 -> Focus 0 next cycle, later strobes write nothing.

Source files
------------

// File: rtl/sdram_line_prefetch.sv
// Double-buffered scanline prefetcher: fills one 12-bit line bank from SDRAM
// while the display reads the other bank, selected by line parity.
module sdram_line_prefetch #(
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter int          H_PIXELS  = 640,
    parameter int          V_LINES   = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic [9:0]  fetch_line,
    input  logic [9:0]  disp_line,
    input  logic [9:0]  pix_x,
    input  logic        pix_valid,
    output logic [11:0] pixel_out,
    output logic [24:0] sdram_Addr,
    output logic        sdram_Focus,
    input  logic [15:0] sdram_Dout,
    input  logic        sdram_R,
    output logic        busy,
    output logic        underrun
);

    localparam logic [24:0] HP    = 25'(H_PIXELS);
    localparam logic [10:0] HLIM  = 11'(H_PIXELS);
    localparam logic [10:0] VLIM  = 11'(V_LINES);
    localparam logic [9:0]  LAST  = 10'(H_PIXELS - 1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state_q;
    logic        bank_q;
    logic [9:0]  count_q;
    logic [24:0] addr_q;
    logic        focus_q;
    logic        busy_q;
    logic        underrun_q;
    logic [11:0] pixel_q;

    logic [11:0] bank0_q [H_PIXELS];
    logic [11:0] bank1_q [H_PIXELS];

    logic        req_ok;
    logic        strobe;
    logic        final_strobe;
    logic [24:0] line_base;
    logic        pix_ok;
    logic        unused_hi;

    assign req_ok       = fetch_req && ({1'b0, fetch_line} < VLIM);
    assign strobe       = (state_q == FETCH) && sdram_R;
    assign final_strobe = strobe && (count_q == LAST);
    assign line_base    = BASE_ADDR + 25'(fetch_line) * HP;
    assign pix_ok       = pix_valid && ({1'b0, pix_x} < HLIM);
    // Upper nibble of the SDRAM word carries no colour information.
    assign unused_hi    = ^sdram_Dout[15:12];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            bank_q     <= 1'b0;
            count_q    <= '0;
            addr_q     <= '0;
            focus_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (req_ok) begin
            // A request landing on the final strobe is a clean hand-off, not an abort.
            if (state_q == FETCH && !final_strobe)
                underrun_q <= 1'b1;
            state_q <= FETCH;
            bank_q  <= fetch_line[0];
            count_q <= '0;
            addr_q  <= line_base;
            focus_q <= 1'b1;
            busy_q  <= 1'b1;
        end else if (strobe) begin
            if (final_strobe) begin
                state_q <= IDLE;
                count_q <= '0;
                focus_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                count_q <= count_q + 10'd1;
                addr_q  <= addr_q + 25'd1;
            end
        end
    end

    // Line storage is never reset; writes are suppressed while Reset is low.
    always_ff @(posedge Clk) begin
        if (Reset && strobe) begin
            if (bank_q)
                bank1_q[count_q] <= sdram_Dout[11:0];
            else
                bank0_q[count_q] <= sdram_Dout[11:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            pixel_q <= '0;
        else if (pix_ok)
            pixel_q <= disp_line[0] ? bank1_q[pix_x] : bank0_q[pix_x];
        else
            pixel_q <= '0;
    end

    assign pixel_out   = pixel_q;
    assign sdram_Addr  = addr_q;
    assign sdram_Focus = focus_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_sdram_line_prefetch.sv
// Directed + randomized bench for sdram_line_prefetch with a line-level
// reference model of both buffer banks and the expected address stream.
module tb_sdram_line_prefetch;

    localparam int          H    = 640;
    localparam int          V    = 480;
    localparam logic [24:0] BASE = 25'h0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [9:0]  fetch_line = '0;
    logic [9:0]  disp_line = '0;
    logic [9:0]  pix_x = '0;
    logic        pix_valid = 1'b0;
    logic [11:0] pixel_out;
    logic [24:0] sdram_Addr;
    logic        sdram_Focus;
    logic [15:0] sdram_Dout = '0;
    logic        sdram_R = 1'b0;
    logic        busy;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    logic [11:0] model [2][H];

    sdram_line_prefetch #(.BASE_ADDR(BASE), .H_PIXELS(H), .V_LINES(V)) dut (
        .Clk(Clk), .Reset(Reset), .fetch_req(fetch_req), .fetch_line(fetch_line),
        .disp_line(disp_line), .pix_x(pix_x), .pix_valid(pix_valid),
        .pixel_out(pixel_out), .sdram_Addr(sdram_Addr), .sdram_Focus(sdram_Focus),
        .sdram_Dout(sdram_Dout), .sdram_R(sdram_R), .busy(busy), .underrun(underrun)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] line_addr(input int line, input int k);
        return BASE + 25'(line * H + k);
    endfunction

    task automatic start_fetch(input int line);
        fetch_req  = 1'b1;
        fetch_line = 10'(line);
        tick();
        fetch_req  = 1'b0;
    endtask

    // Controller stand-in: returns words k0..k0+n-1, gap cycles per word.
    // gap==0 picks a random 1..3 cycle spacing per word.
    task automatic feed(input int line, input int k0, input int n, input int gap,
                        input bit addr_data);
        logic [15:0] d;
        int g;
        for (int k = k0; k < k0 + n; k++) begin
            g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
            for (int w = 1; w < g; w++) begin
                chk("addr_hold", 32'(sdram_Addr), 32'(line_addr(line, k)));
                tick();
            end
            chk("addr", 32'(sdram_Addr), 32'(line_addr(line, k)));
            chk("focus", 32'(sdram_Focus), 32'd1);
            d = addr_data ? 16'(line_addr(line, k)) : 16'($urandom);
            sdram_Dout = d;
            sdram_R    = 1'b1;
            tick();
            sdram_R    = 1'b0;
            model[line % 2][k] = d[11:0];
        end
    endtask

    task automatic read_chk(input string tag, input int dl, input int x, input bit v);
        logic [11:0] exp;
        disp_line = 10'(dl);
        pix_x     = 10'(x);
        pix_valid = v;
        tick();
        exp = (v && x < H) ? model[dl % 2][x] : 12'h000;
        chk(tag, 32'(pixel_out), 32'(exp));
        pix_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] snap;
        tick();
        tick();
        chk("rst_focus", 32'(sdram_Focus), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(sdram_Addr), 32'd0);
        chk("rst_pix", 32'(pixel_out), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        Reset = 1'b1;
        tick();

        // Line 0, data = address, strobe every third cycle.
        start_fetch(0);
        chk("busy_start", 32'(busy), 32'd1);
        feed(0, 0, H, 3, 1'b1);
        chk("l0_focus_end", 32'(sdram_Focus), 32'd0);
        chk("l0_busy_end", 32'(busy), 32'd0);
        for (int x = 0; x < H; x += 71)
            read_chk("l0_word", 0, x, 1'b1);
        read_chk("l0_last", 0, H - 1, 1'b1);
        chk("l0_639_val", 32'(model[0][H-1]), 32'h27f);

        // Last line: address extremes and busy falling one cycle after final strobe.
        start_fetch(479);
        chk("l479_first", 32'(sdram_Addr), 32'd306560);
        feed(479, 0, H - 1, 0, 1'b0);
        chk("l479_last", 32'(sdram_Addr), 32'd307199);
        chk("l479_busy_pre", 32'(busy), 32'd1);
        feed(479, H - 1, 1, 1, 1'b0);
        chk("l479_busy_end", 32'(busy), 32'd0);
        chk("l479_focus_end", 32'(sdram_Focus), 32'd0);

        // Line 1 into bank 1; display reads.
        start_fetch(1);
        feed(1, 0, H, 0, 1'b0);
        read_chk("l1_x5", 1, 5, 1'b1);
        read_chk("l1_novalid", 1, 5, 1'b0);
        read_chk("l1_oob", 1, 700, 1'b1);
        for (int i = 0; i < 16; i++)
            read_chk("rand_read", int'($urandom_range(0, 3)), int'($urandom_range(0, H - 1)), 1'b1);

        // Strobes while idle must not write anything.
        for (int i = 0; i < 4; i++) begin
            sdram_Dout = 16'($urandom);
            sdram_R = 1'b1;
            tick();
        end
        sdram_R = 1'b0;
        read_chk("idle_strobe", 0, 1, 1'b1);
        read_chk("idle_strobe", 0, 2, 1'b1);

        // Out-of-range request is ignored.
        start_fetch(480);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_focus", 32'(sdram_Focus), 32'd0);
        tick();
        chk("bad_busy2", 32'(busy), 32'd0);

        // New request coinciding with the final strobe: clean hand-off.
        start_fetch(4);
        feed(4, 0, H - 1, 1, 1'b0);
        sdram_Dout = 16'($urandom);
        snap = sdram_Dout[11:0];
        sdram_R    = 1'b1;
        fetch_req  = 1'b1;
        fetch_line = 10'd5;
        tick();
        sdram_R    = 1'b0;
        fetch_req  = 1'b0;
        model[0][H-1] = snap;
        chk("hand_underrun", 32'(underrun), 32'd0);
        chk("hand_busy", 32'(busy), 32'd1);
        chk("hand_addr", 32'(sdram_Addr), 32'(line_addr(5, 0)));
        feed(5, 0, H, 0, 1'b0);
        read_chk("hand_final", 0, H - 1, 1'b1);
        read_chk("l5_word", 1, 321, 1'b1);

        // Abort line 2 at count 100 with a request for line 3.
        start_fetch(2);
        feed(2, 0, 100, 0, 1'b0);
        tick();
        start_fetch(3);
        chk("abort_underrun", 32'(underrun), 32'd1);
        chk("abort_addr", 32'(sdram_Addr), 32'd1920);
        chk("abort_focus", 32'(sdram_Focus), 32'd1);
        feed(3, 0, H, 0, 1'b0);
        chk("l3_busy_end", 32'(busy), 32'd0);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        read_chk("l3_word", 3, 17, 1'b1);
        read_chk("l3_last", 3, H - 1, 1'b1);
        read_chk("l2_partial", 2, 99, 1'b1);
        read_chk("l2_untouched", 2, 100, 1'b1);

        // Reset mid-fetch at count 50.
        start_fetch(6);
        feed(6, 0, 50, 0, 1'b0);
        Reset = 1'b0;
        tick();
        chk("mrst_focus", 32'(sdram_Focus), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_addr", 32'(sdram_Addr), 32'd0);
        chk("mrst_underrun", 32'(underrun), 32'd0);
        chk("mrst_pix", 32'(pixel_out), 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sdram_Dout = 16'($urandom);
            sdram_R = 1'b1;
            tick();
            sdram_R = 1'b0;
            tick();
        end
        chk("post_rst_focus", 32'(sdram_Focus), 32'd0);
        read_chk("l6_written", 0, 49, 1'b1);
        read_chk("l6_nowrite", 0, 50, 1'b1);
        read_chk("l6_nowrite", 0, 51, 1'b1);
        read_chk("l6_first", 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
